// File: rtl/simple_spi_master.sv
// -----------------------------------------------------------------------------
// simple_spi_master
//
// Controller-side SPI engine. One accepted request becomes one complete
// transaction:
//   1. CS is driven low.
//   2. The command is shifted out LSB-first.
//   3. SCK is held low for a gap so the peripheral can stage its reply.
//   4. The data word is exchanged LSB-first in both directions.
//   5. CS is released and the captured reply is returned with a done pulse.
//
// SCK idles low. SDO is set up while SCK is low, and SDI is sampled on the
// clk edge that raises SCK.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          transaction request, sampled only while busy = 0
//   command        command bits, captured on acceptance
//   word_to_send   data word, captured on acceptance
//   busy           high from the cycle after acceptance to the end of CS recovery
//   done           one-cycle pulse, word_received valid in the same cycle
//   word_received  word shifted in during the data phase, held until next done
//   cs             chip select, active low
//   sck            serial clock
//   sdo            controller-to-peripheral data
//   sdi            peripheral-to-controller data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module simple_spi_master #(
    parameter int COMMAND_SIZE = 8,
    parameter int WORD_SIZE    = 32,
    parameter int HALF_PERIOD  = 4,
    parameter int GAP_CYCLES   = 8,
    parameter int CS_IDLE      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [COMMAND_SIZE-1:0] command,
    input  logic [WORD_SIZE-1:0]    word_to_send,
    output logic                    busy,
    output logic                    done,
    output logic [WORD_SIZE-1:0]    word_received,
    output logic                    cs,
    output logic                    sck,
    output logic                    sdo,
    input  logic                    sdi
);

    localparam int TOTAL = COMMAND_SIZE + WORD_SIZE;
    localparam int BW    = $clog2(TOTAL + 1);

    // One timer serves every timed phase, so it is sized for the longest one.
    localparam int TMAX_A = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int TMAX   = (TMAX_A > CS_IDLE) ? TMAX_A : CS_IDLE;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] HP_LAST   = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] IDLE_LAST = TW'(CS_IDLE - 1);
    localparam logic [BW-1:0] CMD_LAST  = BW'(COMMAND_SIZE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(TOTAL - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        GAP,
        DATA,
        HOLD,
        RECOVER
    } state_t;

    state_t                 state;
    logic [TW-1:0]          timer;
    logic [BW-1:0]          bit_cnt;
    // Command and word share one transmit register. Once the command bits have
    // shifted out, bit 0 already holds word_to_send[0].
    logic [TOTAL-1:0]       tx;
    logic [WORD_SIZE-1:0]   rx;

    // NOTE: every register here, shift registers included, is cleared by the
    // async reset, so an aborted transaction leaves no stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            bit_cnt       <= '0;
            tx            <= '0;
            rx            <= '0;
            word_received <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cs            <= 1'b1;
            sck           <= 1'b0;
            sdo           <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments. A later assignment in
            // the same branch (e.g. done below) overrides this default.
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        tx      <= {word_to_send, command};
                        rx      <= '0;
                        bit_cnt <= '0;
                        timer   <= '0;
                        cs      <= 1'b0;
                        sck     <= 1'b0;
                        sdo     <= command[0];
                        busy    <= 1'b1;
                        state   <= CMD;
                    end
                end

                CMD, DATA: begin
                    if (timer != HP_LAST) begin
                        timer <= timer + 1'b1;
                    end else begin
                        timer <= '0;
                        if (!sck) begin
                            // Rising edge: capture sdi (meaningful only in DATA).
                            sck <= 1'b1;
                            if (state == DATA) begin
                                rx <= {sdi, rx[WORD_SIZE-1:1]};
                            end
                        end else begin
                            // Falling edge: advance to the next bit.
                            sck     <= 1'b0;
                            tx      <= tx >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                            sdo     <= tx[1];
                            if (state == CMD && bit_cnt == CMD_LAST) begin
                                if (GAP_CYCLES > 0) begin
                                    sdo   <= 1'b0;
                                    state <= GAP;
                                end else begin
                                    state <= DATA;
                                end
                            end else if (state == DATA && bit_cnt == DATA_LAST) begin
                                sdo   <= 1'b0;
                                state <= HOLD;
                            end
                        end
                    end
                end

                GAP: begin
                    if (timer != GAP_LAST) begin
                        timer <= timer + 1'b1;
                    end else begin
                        timer <= '0;
                        sdo   <= tx[0];
                        state <= DATA;
                    end
                end

                HOLD: begin
                    if (timer != HP_LAST) begin
                        timer <= timer + 1'b1;
                    end else begin
                        timer         <= '0;
                        cs            <= 1'b1;
                        done          <= 1'b1;
                        word_received <= rx;
                        state         <= RECOVER;
                    end
                end

                RECOVER: begin
                    if (timer != IDLE_LAST) begin
                        timer <= timer + 1'b1;
                    end else begin
                        timer <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_spi_master.sv
// -----------------------------------------------------------------------------
// tb_simple_spi_master
//
// Self-checking bench for simple_spi_master.
//   - dut:  default parameters, driven against a behavioral SPI peripheral that
//           records the command and word it receives and returns a reply word.
//   - dut2: HALF_PERIOD=1, GAP_CYCLES=0, CS_IDLE=1, with sdi looped back to sdo.
//
// Cycle n of a transaction is the clk period whose outputs are sampled at the
// n-th falling clk edge after the accepting rising edge. In that numbering,
// cs is low on cycles 1..332 and done pulses on cycle 333.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_simple_spi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  command = '0;
    logic [31:0] word_to_send = '0;
    logic        busy, done, cs, sck, sdo, sdi;
    logic [31:0] word_received;

    logic        start2 = 1'b0;
    logic [7:0]  command2 = '0;
    logic [31:0] word2 = '0;
    logic        busy2, done2, cs2, sck2, sdo2;
    logic [31:0] word_received2;

    always #5 clk = ~clk;

    simple_spi_master #(
        .COMMAND_SIZE(8), .WORD_SIZE(32), .HALF_PERIOD(4), .GAP_CYCLES(8), .CS_IDLE(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .command(command),
        .word_to_send(word_to_send), .busy(busy), .done(done),
        .word_received(word_received), .cs(cs), .sck(sck), .sdo(sdo), .sdi(sdi)
    );

    simple_spi_master #(
        .COMMAND_SIZE(8), .WORD_SIZE(32), .HALF_PERIOD(1), .GAP_CYCLES(0), .CS_IDLE(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .command(command2),
        .word_to_send(word2), .busy(busy2), .done(done2),
        .word_received(word_received2), .cs(cs2), .sck(sck2), .sdo(sdo2), .sdi(sdo2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor + peripheral model for dut ----------------
    logic [31:0] reply = '0;
    logic [31:0] reply_sh = '0;
    logic [7:0]  cmd_seen = '0;
    logic [31:0] word_seen = '0;
    logic        sdi_r = 1'b0;
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_sdo = 1'b0;
    int ncyc = 0, cs_fall_t = 0, cs_rise_t = 0, done_t = 0;
    int n_done = 0, n_rise = 0, n_cs_fall = 0, sdo_bad = 0, p_rise = 0, p_fall = 0;
    logic [31:0] last_rx = '0;

    assign sdi = sdi_r;

    always @(negedge clk) begin
        ncyc++;
        if (!cs && prev_cs) begin
            cs_fall_t = ncyc;
            n_cs_fall++;
            p_rise    = 0;
            p_fall    = 0;
            cmd_seen  = '0;
            word_seen = '0;
            reply_sh  = '0;
        end
        if (cs && !prev_cs) cs_rise_t = ncyc;
        if (done) begin
            done_t  = ncyc;
            n_done++;
            last_rx = word_received;
        end
        if (sck && !prev_sck) begin
            n_rise++;
            if (sdo !== prev_sdo) sdo_bad++;
            if (!cs) begin
                if (p_rise < 8) cmd_seen = {sdo, cmd_seen[7:1]};
                else if (p_rise < 40) word_seen = {sdo, word_seen[31:1]};
                p_rise++;
            end
        end
        if (!sck && prev_sck && !cs) begin
            p_fall++;
            // The reply is staged after the last command bit and shifts once
            // per data-phase falling edge.
            if (p_fall == 8) reply_sh = reply;
            else if (p_fall > 8) reply_sh = reply_sh >> 1;
        end
        if (cs) reply_sh = '0;
        sdi_r    = reply_sh[0];
        prev_cs  = cs;
        prev_sck = sck;
        prev_sdo = sdo;
    end

    // ---------------- monitor for dut2 ----------------
    logic prev_cs2 = 1'b1, prev_sck2 = 1'b0;
    int c2_fall_t = 0, c2_rise_t = 0, s2_last_rise = 0, s2_period = 0, n2_rise = 0, n2_done = 0;
    logic [31:0] rx2 = '0;

    always @(negedge clk) begin
        if (!cs2 && prev_cs2) begin
            c2_fall_t = ncyc;
            n2_rise   = 0;
        end
        if (cs2 && !prev_cs2) c2_rise_t = ncyc;
        if (sck2 && !prev_sck2) begin
            if (n2_rise > 0) s2_period = ncyc - s2_last_rise;
            s2_last_rise = ncyc;
            n2_rise++;
        end
        if (done2) begin
            n2_done++;
            rx2 = word_received2;
        end
        prev_cs2  = cs2;
        prev_sck2 = sck2;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int k = 0;
        while (n_done == d0 && k < 2000) begin
            tick();
            k++;
        end
        check(name, 64'(n_done != d0), 64'd1);
    endtask

    task automatic run_txn(input logic [7:0] c, input logic [31:0] w,
                           input logic [31:0] r, input logic [31:0] exp_rx);
        int d0, r0, k, busy_t;
        command      = c;
        word_to_send = w;
        reply        = r;
        d0 = n_done;
        r0 = n_rise;
        pulse_start();
        wait_done(d0, "done_seen");
        k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        busy_t = ncyc;
        check("word_received", last_rx, exp_rx);
        check("model_cmd", cmd_seen, c);
        check("model_word", word_seen, w);
        check("sck_rises", n_rise - r0, 40);
        check("cs_low_len", cs_rise_t - cs_fall_t, 332);
        check("done_cycle", done_t - cs_fall_t + 1, 333);
        check("busy_fall_cycle", busy_t - cs_fall_t + 1, 341);
        check("done_width", n_done - d0, 1);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] word;
        logic [31:0] reply;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, d0, k;

        vecs[0] = '{8'hA5, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{8'h01, 32'h80000000, 32'h00000001, 32'h00000001};
        vecs[2] = '{8'hFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[3] = '{8'h00, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        vecs[4] = '{8'h3C, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A};

        // Reset state
        repeat (3) tick();
        check("rst_cs", cs, 1);
        check("rst_sck", sck, 0);
        check("rst_sdo", sdo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_word_received", word_received, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Table-driven transactions
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].cmd, vecs[i].word, vecs[i].reply, vecs[i].exp_rx);
            repeat (2) tick();
        end

        // Busy rejection, then start held high for back-to-back transactions
        f0 = n_cs_fall;
        d0 = n_done;
        command      = 8'h5A;
        word_to_send = 32'h0F0F0F0F;
        reply        = 32'h13579BDF;
        pulse_start();
        k = 0;
        while (ncyc < cs_fall_t + 99 && k < 200) begin
            tick();
            k++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (ncyc < cs_fall_t + 299 && k < 400) begin
            tick();
            k++;
        end
        check("busy_reject_no_extra_cs", n_cs_fall - f0, 1);
        check("busy_reject_cs_low", cs, 0);
        command      = 8'hC6;
        word_to_send = 32'hCAFEF00D;
        reply        = 32'h2468ACE0;
        start        = 1'b1;
        wait_done(d0, "b2b_first_done");
        check("b2b_first_rx", last_rx, 32'h13579BDF);
        check("b2b_first_cmd", cmd_seen, 8'h5A);
        check("b2b_first_word", word_seen, 32'h0F0F0F0F);
        k = 0;
        while (n_cs_fall < f0 + 2 && k < 50) begin
            tick();
            k++;
        end
        start = 1'b0;
        check("b2b_second_cs_fall", n_cs_fall - f0, 2);
        check("b2b_cs_high_gap", cs_fall_t - cs_rise_t, 9);
        wait_done(d0 + 1, "b2b_second_done");
        check("b2b_second_rx", last_rx, 32'h2468ACE0);
        check("b2b_second_cmd", cmd_seen, 8'hC6);
        check("b2b_second_word", word_seen, 32'hCAFEF00D);
        repeat (40) tick();
        check("b2b_no_third_txn", n_cs_fall - f0, 2);

        // Reset in the middle of the data phase
        d0 = n_done;
        command      = 8'h77;
        word_to_send = 32'h11223344;
        reply        = 32'h55667788;
        pulse_start();
        k = 0;
        while (ncyc < cs_fall_t + 199 && k < 400) begin
            tick();
            k++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_cs", cs, 1);
        check("abort_sck", sck, 0);
        check("abort_sdo", sdo, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_word_received", word_received, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (400) tick();
        check("abort_no_done", n_done - d0, 0);
        run_txn(8'h99, 32'h87654321, 32'h0BADCAFE, 32'h0BADCAFE);

        // Corner parameters on dut2 with loopback
        command2 = 8'hC3;
        word2    = 32'h1234ABCD;
        d0 = n2_done;
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        k = 0;
        while (n2_done == d0 && k < 500) begin
            tick();
            k++;
        end
        check("corner_done_seen", 64'(n2_done != d0), 64'd1);
        check("corner_rx", rx2, 32'h1234ABCD);
        check("corner_cs_low_len", c2_rise_t - c2_fall_t, 81);
        check("corner_sck_period", s2_period, 2);
        check("corner_sck_rises", n2_rise, 40);
        repeat (3) tick();
        check("corner_busy_low", busy2, 0);

        check("sdo_stable_on_rise", sdo_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_spi_master.md
# simple_spi_master

Controller-side SPI engine for PicoView test designs: it drives the CS/SCK/SDO lines that our SPI command peripheral listens to. A local requester hands over one command byte plus one data word. The block then runs a complete transaction: assert CS, shift the command LSB-first, pause for the peripheral to stage its reply, and exchange the data word LSB-first in both directions. It returns the captured reply with a done pulse. The block sits in the FPGA-side test harness and drives the peripheral-under-test or an external SPI target.

## Interface
- COMMAND_SIZE, 8, command bits per transaction
- WORD_SIZE, 32, data bits per transaction
- HALF_PERIOD, 4, clk cycles per SCK half-period; must be ≥1
- GAP_CYCLES, 8, extra SCK-low clk cycles between the command and data phases (peripheral staging time); must be ≥0
- CS_IDLE, 8, minimum clk cycles CS stays high after a transaction; must be ≥1

- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a transaction; sampled only while busy=0
- command  input  COMMAND_SIZE  command byte, captured when start is accepted
- word_to_send  input  WORD_SIZE  data word, captured when start is accepted
- busy  output  1  high from the cycle after acceptance through the end of CS recovery
- done  output  1  single-cycle pulse; word_received is valid in the same cycle
- word_received  output  WORD_SIZE  word shifted in during the data phase; held until the next done
- cs  output  1  chip select, active low
- sck  output  1  serial clock; idles low
- sdo  output  1  controller-to-peripheral data
- sdi  input  1  peripheral-to-controller data

## Operation
- The state machine has these states: IDLE, CMD, GAP, DATA, HOLD, RECOVER.
- IDLE:
  - Outputs are cs=1, sck=0, sdo=0, busy=0.
  - When start=1, latch command and word_to_send into shift registers, clear the bit counter, and go to CMD.
- Per-bit framing, identical in CMD and DATA:
  - Low phase: sck=0 for HALF_PERIOD cycles, with sdo = the shift register's bit 0.
  - High phase: sck=1 for HALF_PERIOD cycles.
  - On the clk edge that raises sck, sample sdi. In DATA only, shift the receive register right with sdi inserted at the MSB: rx <= {sdi, rx[WORD_SIZE-1:1]}.
  - On the clk edge that lowers sck, shift the transmit register right and increment the bit counter.
- CMD:
  - Send COMMAND_SIZE bits; sdi is ignored in this phase.
  - After the last falling edge, go to GAP; if GAP_CYCLES=0, go straight to DATA.
- GAP: hold sck=0, cs=0, sdo=0 for GAP_CYCLES cycles, then go to DATA.
- DATA: send and receive WORD_SIZE bits. After the last falling edge, go to HOLD.
- HOLD: hold sck=0, cs=0 for HALF_PERIOD cycles. On exit, set cs=1, copy rx to word_received, pulse done, and go to RECOVER.
- RECOVER: hold cs=1 and busy=1 for CS_IDLE cycles, then go to IDLE. start is ignored here.
- Bit order is LSB first in both directions. The bit counter spans 0..COMMAND_SIZE+WORD_SIZE.
- Reset, asynchronous and valid at any time including mid-transaction:
  - State returns to IDLE; all counters and shift registers clear.
  - Outputs go to cs=1, sck=0, sdo=0, busy=0, done=0, word_received=0.
  - No done pulse is issued for the aborted transaction.

## Timing
- Cycle numbering: cycle 0 is the edge where start is sampled high in IDLE.
  - From cycle 1: cs=0, sck=0, sdo=command[0], busy=1.
  - First sck rise at cycle 1+HALF_PERIOD.
- cs low duration = 2·HALF_PERIOD·(COMMAND_SIZE+WORD_SIZE) + GAP_CYCLES + HALF_PERIOD. With defaults this is 332 cycles.
- done pulses on the cycle cs returns high: cycle 333 with defaults.
- busy falls CS_IDLE cycles after done: cycle 341 with defaults. The earliest next acceptance is cycle 341, which puts the next cs low at cycle 342.
- Exactly COMMAND_SIZE+WORD_SIZE sck rising edges occur per transaction.
- sdo changes only on cycles where sck is low or falling. It never changes on a rising-edge cycle.
- start held continuously high gives back-to-back transactions with a cs high gap of exactly CS_IDLE+1 cycles.

## Test plan
- Reset: assert rst_n=0 mid-stimulus → cs=1, sck=0, sdo=0, busy=0, done=0, word_received=0 immediately, without waiting for a clk edge.
- Single transaction, defaults, with a behavioral peripheral model that replies 0xDEADBEEF:
  - Stimulus: command=0xA5, word_to_send=0x12345678.
  - Model receives command 0xA5 and word 0x12345678.
  - word_received=0xDEADBEEF with done high for one cycle at cycle 333; 40 sck rises counted.
- Bit order: command=0x01, word_to_send=0x80000000, sdi tied high during the first data bit only → sdo high on command bit 0 and data bit 31 only; word_received=0x00000001.
- Busy rejection and back-to-back:
  - Pulse start again at cycle 100 → ignored; no extra transaction.
  - Then hold start high → second cs fall exactly 9 cycles after the first cs rise.
- Reset mid-DATA: drop rst_n at cycle 200 → cs high, no done; a new transaction after release completes normally with correct data.
- Corner parameters: HALF_PERIOD=1, GAP_CYCLES=0, CS_IDLE=1 → sck period 2 cycles, cs low for 81 cycles, data correct with an ideal loopback (sdi=sdo).
